// File: rtl/ntt_ctrl.sv
// In-place forward NTT sequencer over Z_q (q = 8380417) driving an external coefficient RAM
// and twiddle ROM, with a single combinational Cooley-Tukey butterfly on the write-back path.

module ntt_bu #(
  parameter int unsigned DW = 23
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] tf,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b
);
  localparam int unsigned PW = 2 * DW;
  localparam logic [DW-1:0] Q = DW'(8380417);

  logic [PW-1:0] prod;
  logic [DW-1:0] t;
  logic [DW:0]   sum;
  logic [DW:0]   dif;

  // a = x + tf*y, b = x - tf*y, both reduced into [0, q)
  always_comb begin
    prod = PW'(tf) * PW'(y);
    t    = DW'(prod % PW'(Q));
    sum  = (DW+1)'(x) + (DW+1)'(t);
    a    = (sum >= (DW+1)'(Q)) ? DW'(sum - (DW+1)'(Q)) : DW'(sum);
    dif  = (x >= t) ? ((DW+1)'(x) - (DW+1)'(t))
                    : ((DW+1)'(x) + (DW+1)'(Q) - (DW+1)'(t));
    b    = DW'(dif);
  end
endmodule

module ntt_ctrl #(
  parameter int unsigned LOG_N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  input  logic [22:0]      rd_data_a,
  input  logic [22:0]      rd_data_b,
  output logic [LOG_N-1:0] zeta_addr,
  input  logic [22:0]      zeta_data,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [22:0]      wr_data_a,
  output logic [22:0]      wr_data_b
);
  localparam int unsigned AW = LOG_N;
  localparam int unsigned IW = LOG_N - 1;
  localparam int unsigned SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int unsigned DW = 23;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] stage;
  logic [IW-1:0] idx;

  // Lower butterfly index: zero bit inserted at position L = LOG_N-1-s.
  function automatic logic [AW-1:0] lo_addr(input logic [SW-1:0] s, input logic [IW-1:0] i);
    logic [AW-1:0] l;
    logic [AW-1:0] ie;
    logic [AW-1:0] mask;
    l    = AW'(LOG_N - 1) - AW'(s);
    ie   = AW'(i);
    mask = (AW'(1) << l) - AW'(1);
    return ((ie >> l) << (l + AW'(1))) | (ie & mask);
  endfunction

  function automatic logic [AW-1:0] hi_addr(input logic [SW-1:0] s, input logic [IW-1:0] i);
    logic [AW-1:0] l;
    l = AW'(LOG_N - 1) - AW'(s);
    return lo_addr(s, i) | (AW'(1) << l);
  endfunction

  function automatic logic [AW-1:0] zeta_idx(input logic [SW-1:0] s, input logic [IW-1:0] i);
    logic [AW-1:0] l;
    l = AW'(LOG_N - 1) - AW'(s);
    return (AW'(1) << s) + (AW'(i) >> l);
  endfunction

  // Outputs always describe the butterfly (stage, idx) issued in the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_addr <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            stage     <= '0;
            idx       <= '0;
            rd_addr_a <= lo_addr('0, '0);
            rd_addr_b <= hi_addr('0, '0);
            zeta_addr <= zeta_idx('0, '0);
          end
        end
        RUN: begin
          if (&idx) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            idx       <= idx + IW'(1);
            rd_addr_a <= lo_addr(stage, idx + IW'(1));
            rd_addr_b <= hi_addr(stage, idx + IW'(1));
            zeta_addr <= zeta_idx(stage, idx + IW'(1));
          end
        end
        DRAIN: begin
          // Bubble lets the stage's final write land before the next stage reads.
          if (stage == SW'(LOG_N - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= RUN;
            stage     <= stage + SW'(1);
            idx       <= '0;
            rd_en     <= 1'b1;
            rd_addr_a <= lo_addr(stage + SW'(1), '0);
            rd_addr_b <= hi_addr(stage + SW'(1), '0);
            zeta_addr <= zeta_idx(stage + SW'(1), '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ntt_bu #(.DW(DW)) u_bu (
    .x  (rd_data_a),
    .y  (rd_data_b),
    .tf (zeta_data),
    .a  (wr_data_a),
    .b  (wr_data_b)
  );
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for an in-place forward NTT over Z_q, q = 8380417, N = 2^LOG_N coefficients of 23 bits. It instantiates one combinational `BU` butterfly (A = X + TF·Y mod q, B = X − TF·Y mod q). It walks the Cooley-Tukey schedule: stage lengths len = N/2 down to 1, twiddle index k starting at 1. On every issue cycle it drives one butterfly's read addresses to an external coefficient RAM and a twiddle ROM, then writes both results back one cycle later.

## Interface
- LOG_N, default 8: log2 of transform size. Address width is LOG_N. The default gives 256 points.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one full NTT. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last write has committed
- rd_en  out  1  read strobe for the RAM and ROM
- rd_addr_a  out  LOG_N  RAM port A read address (lo index j)
- rd_addr_b  out  LOG_N  RAM port B read address (hi index j+len)
- rd_data_a, rd_data_b  in  23  RAM read data. Synchronous: valid the cycle after rd_en.
- zeta_addr  out  LOG_N  twiddle ROM address k
- zeta_data  in  23  ROM data. Synchronous: valid the cycle after rd_en.
- wr_en  out  1  RAM write strobe. The RAM commits both ports on the rising edge when wr_en = 1.
- wr_addr_a, wr_addr_b  out  LOG_N  write addresses, registered copies of the read addresses
- wr_data_a, wr_data_b  out  23  BU outputs A and B. Combinational from rd_data_a, rd_data_b and zeta_data.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN after the last butterfly of a stage is issued.
  - DRAIN → RUN when stage < LOG_N−1, incrementing stage and clearing the butterfly counter.
  - DRAIN → DONE after the last stage.
  - DONE → IDLE unconditionally.
- Counters: stage s runs 0..LOG_N−1. Butterfly index i runs 0..N/2−1. Let L = LOG_N−1−s, so len = 2^L.
- Address generation in RUN, with rd_en = 1:
  - lo = {i[LOG_N−2:L], 1'b0, i[L−1:0]}, i.e. a zero bit inserted at position L.
  - rd_addr_a = lo.
  - rd_addr_b = lo + len. The add is carry-free because bit L of lo is 0.
  - zeta_addr = 2^s + (i >> L).
- Write-back pipeline:
  - Issue-stage addresses and rd_en are registered into wr_addr_a, wr_addr_b and wr_en.
  - wr_en = 1 exactly in the cycle after each rd_en = 1 cycle.
- DRAIN: one bubble per stage. rd_en = 0 and no reads are issued. The final write of the stage (wr_en = 1) happens here. This guarantees that no read of stage s+1 precedes a write of stage s.
- DONE state drives done = 1 and busy = 0, with rd_en = wr_en = 0.
- Reset values (async, immediate): state IDLE, busy 0, done 0, rd_en 0, wr_en 0, all address outputs 0, all counters 0.
- rd_addr_* and zeta_addr are don't-care when rd_en = 0. wr_data_* are don't-care when wr_en = 0.
- start while busy: ignored. start in the DONE cycle: ignored. Only a start in IDLE is accepted.
- Reset mid-run aborts immediately. Any write whose edge has not yet occurred is dropped, RAM contents are partial, and no done is produced.
- Arithmetic lives entirely in BU. The controller performs no modular operations and trusts the RAM to hold values < q.

## Timing
- start sampled high in IDLE at edge 0 → busy = 1 from cycle 1. The first issue is in cycle 1, with rd_addr_a = 0, rd_addr_b = N/2 and zeta_addr = 1.
- Each stage takes N/2 issue cycles plus 1 DRAIN cycle.
- done pulses in cycle LOG_N·(N/2+1)+1, which is cycle 1033 for LOG_N = 8. busy falls in that same cycle.
- Throughput: one butterfly per cycle inside a stage.
- Write latency: 1 cycle from issue.
- Total busy cycles: LOG_N·(N/2+1), which is 1032 for LOG_N = 8.

## Test plan
- Reset: hold rst_n = 0 → busy, done, rd_en, wr_en and all addresses read 0. Then pulse start with rst_n = 1 → busy = 1 in the next cycle.
- Zero vector, LOG_N = 8 → every wr_data is 0, done pulses exactly at cycle 1033, and exactly 1024 cycles have wr_en = 1.
- Impulse: a[0] = 1, rest 0, real Dilithium zeta ROM → every RAM word equals 1 after done. Random input must match a software NTT mod 8380417 bit-exactly.
- Address trace: check the following issue cycles.
  - Cycle 1: (0, 128, k = 1).
  - Cycle 129: bubble.
  - Cycle 130: (0, 64, k = 2).
  - Last issue (stage 7, i = 127): (254, 255, k = 255).
  - Each wr_addr matches the rd_addr of the previous cycle.
- Handshake: start asserted at cycle 500 and again in the done cycle → both ignored. A start one cycle later → a new run begins.
- Reset mid-run: drop rst_n at cycle 600 → outputs go to 0 immediately and no done is produced. After reloading the RAM, a new start yields the correct impulse result (all 1s).
